// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned MD_XLEN = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic rs1_is_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic rs2_is_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Executor <-> multiply/divide sequencer handshake.
interface muldiv_if #(
  parameter int unsigned XLEN = muldiv_pkg::MD_XLEN
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            abort;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, rs1_data, rs2_data, abort,
                  input  busy, done, result);
  modport slave  (input  start, op, rs1_data, rs2_data, abort,
                  output busy, done, result);
endinterface

// File: rtl/muldiv_sequencer_step.sv
// One iteration: add-and-shift-right for multiply, restoring trial-subtract-shift-left for divide.
module muldiv_sequencer_step #(
  parameter int unsigned XLEN = muldiv_pkg::MD_XLEN
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_c
);
  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;
  logic          ge;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
  // Divide: acc = {remainder, dividend/quotient}; borrow bit tells whether divisor fits
  assign rem_sh = acc_i[2*XLEN-1:XLEN-1];
  assign trial  = rem_sh - {1'b0, opnd_i};
  assign ge     = ~trial[XLEN];

  always_comb begin
    acc_c = {sum, acc_i[XLEN-1:1]};
    if (is_div_i) begin
      acc_c = {(ge ? trial[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_i[XLEN-2:0], ge};
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: operand magnitudes, XLEN steps, sign fix, result.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN      = MD_XLEN,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  md
);
  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d, op_in;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d, step_acc;
  logic              neg_q, neg_d, fast_q, fast_d;
  logic [CW-1:0]     count_q, count_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d, fix_result;
  logic              s1, s2, neg_start;
  logic [XLEN-1:0]   mag1, mag2;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot_f, rem_f;

  assign op_in = md_op_e'(md.op);

  // Operand sign/magnitude at launch
  always_comb begin
    s1   = rs1_is_signed(op_in) & md.rs1_data[XLEN-1];
    s2   = rs2_is_signed(op_in) & md.rs2_data[XLEN-1];
    mag1 = s1 ? -md.rs1_data : md.rs1_data;
    mag2 = s2 ? -md.rs2_data : md.rs2_data;
    case (op_in)
      MD_MULH, MD_DIV:   neg_start = s1 ^ s2;
      MD_MULHSU, MD_REM: neg_start = s1;
      default:           neg_start = 1'b0;
    endcase
  end

  muldiv_sequencer_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_is_div(op_q)),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_c    (step_acc)
  );

  // Sign fix and result select; fast-path values are preloaded already signed
  always_comb begin
    prod   = neg_q ? -acc_q : acc_q;
    quot_f = (neg_q && !fast_q) ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
    rem_f  = (neg_q && !fast_q) ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                      fix_result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             fix_result = quot_f;
      default:                     fix_result = rem_f;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    fast_d   = fast_q;
    count_d  = count_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (md.start) begin
          op_d    = op_in;
          neg_d   = neg_start;
          fast_d  = 1'b0;
          count_d = '0;
          state_d = ST_CALC;
          if (op_is_div(op_in)) begin
            acc_d  = {XLEN'(0), mag1};
            opnd_d = mag2;
          end else begin
            acc_d  = {XLEN'(0), mag2};
            opnd_d = mag1;
          end
          // Divide-by-zero and signed overflow skip the iterations entirely
          if (EARLY_OUT && op_is_div(op_in)) begin
            if (md.rs2_data == '0) begin
              fast_d  = 1'b1;
              acc_d   = {md.rs1_data, {XLEN{1'b1}}};
              state_d = ST_FIX;
            end else if (rs1_is_signed(op_in) && md.rs1_data == SMIN && md.rs2_data == '1) begin
              fast_d  = 1'b1;
              acc_d   = {XLEN'(0), SMIN};
              state_d = ST_FIX;
            end
          end
        end
      end
      ST_CALC: begin
        acc_d = step_acc;
        if (count_q == CW'(XLEN - 1)) state_d = ST_FIX;
        else                          count_d = count_q + CW'(1);
      end
      ST_FIX: begin
        result_d = fix_result;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (md.abort && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= MD_MUL;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      fast_q   <= 1'b0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      fast_q   <= fast_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign md.busy   = busy_q;
  assign md.done   = done_q;
  assign md.result = result_q;
endmodule
